// File: rtl/fpu_pkg.sv
// Shared binary32 constants, flag bit positions and divider FSM states for the FPU execute path.
package fpu_pkg;
  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;
  localparam logic signed [9:0] BIAS = 10'sd127;
  localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;

  // o_flags = {NV,DZ,OF,UF,NX}
  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  typedef enum logic [2:0] {
    S_IDLE, S_PRENORM, S_DIVIDE, S_POST, S_DONE
  } div_state_t;
endpackage

// File: rtl/fpu_div_step.sv
// One restoring-division step: trial subtract, emit quotient bit, shift the partial remainder.
module fpu_div_step (
  input  logic [24:0] rem,
  input  logic [23:0] dvsr,
  output logic [24:0] rem_nxt,
  output logic        q_bit
);
  logic [23:0] diff;

  // When the subtract succeeds the difference is below dvsr, so 24 bits hold it.
  assign q_bit   = rem >= {1'b0, dvsr};
  assign diff    = rem[23:0] - dvsr;
  assign rem_nxt = q_bit ? {diff, 1'b0} : {rem[23:0], 1'b0};
endmodule

// File: rtl/fp32_divider_seq.sv
// Iterative binary32 divider (radix-2 restoring, truncating). Flags are built only when
// FPU_DIV_FLAGS_EN is defined; otherwise o_flags is tied to zero.
module fp32_divider_seq
  import fpu_pkg::*;
#(
  parameter logic [31:0] CANON_NAN  = FP32_QNAN,
  parameter int          RADIX_BITS = 1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic        o_valid,
  input  logic        i_ack,
  output logic [31:0] o_result,
  output logic [4:0]  o_flags
);
  localparam int         DIV_CYCLES = 26 / RADIX_BITS;
  localparam logic [4:0] DIV_LAST   = 5'(DIV_CYCLES - 1);

  div_state_t        state;
  logic              sign_q;
  logic signed [9:0] ea, eb;
  logic [24:0]       rem;
  logic [23:0]       mb;
  logic [25:0]       q;
  logic [4:0]        cnt;

  logic              sa, sb;
  logic [EXP_W-1:0]  xa, xb;
  logic [FRAC_W-1:0] fa, fb;
  logic              a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic              spec_hit;
  logic [31:0]       spec_res;
  logic [4:0]        spec_flg;

  assign {sa, xa, fa} = i_a;
  assign {sb, xb, fb} = i_b;
  assign a_zero = (xa == '0) && (fa == '0);
  assign b_zero = (xb == '0) && (fb == '0);
  assign a_inf  = (xa == '1) && (fa == '0);
  assign b_inf  = (xb == '1) && (fb == '0);
  assign a_nan  = (xa == '1) && (fa != '0);
  assign b_nan  = (xb == '1) && (fb != '0);

  // inf/0 falls under inf/x, so the inf check precedes the divide-by-zero check.
  always_comb begin
    spec_hit = 1'b1;
    spec_res = '0;
    spec_flg = '0;
    if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
      spec_res          = CANON_NAN;
      spec_flg[FLAG_NV] = 1'b1;
    end else if (a_inf) begin
      spec_res = {sa ^ sb, 8'hFF, 23'd0};
    end else if (b_zero) begin
      spec_res          = {sa ^ sb, 8'hFF, 23'd0};
      spec_flg[FLAG_DZ] = 1'b1;
    end else if (a_zero || b_inf) begin
      spec_res = {sa ^ sb, 31'd0};
    end else begin
      spec_hit = 1'b0;
    end
  end

  // Normalization of denormal inputs, one bit per cycle per operand.
  logic [24:0]       rem_sh;
  logic [23:0]       mb_sh;
  logic signed [9:0] ea_sh, eb_sh;

  assign rem_sh = rem[23] ? rem : {rem[23:0], 1'b0};
  assign ea_sh  = rem[23] ? ea  : ea - 10'sd1;
  assign mb_sh  = mb[23]  ? mb  : {mb[22:0], 1'b0};
  assign eb_sh  = mb[23]  ? eb  : eb - 10'sd1;

  logic [24:0]           rem_chain [RADIX_BITS+1];
  logic [RADIX_BITS-1:0] q_bits;

  assign rem_chain[0] = rem;
  for (genvar g = 0; g < RADIX_BITS; g++) begin : g_step
    fpu_div_step u_step (
      .rem    (rem_chain[g]),
      .dvsr   (mb),
      .rem_nxt(rem_chain[g+1]),
      .q_bit  (q_bits[RADIX_BITS-1-g])
    );
  end

  logic signed [9:0] e_raw, e_adj;
  logic [22:0]       frac;
  logic              post_ovf, post_unf;
  logic [31:0]       post_res;

  always_comb begin
    e_raw    = ea - eb + BIAS;
    e_adj    = q[25] ? e_raw : e_raw - 10'sd1;
    frac     = q[25] ? q[24:2] : q[23:1];
    post_ovf = e_adj >= 10'sd255;
    post_unf = e_adj <= 10'sd0;
    post_res = {sign_q, e_adj[7:0], frac};
    if (post_ovf)      post_res = {sign_q, 8'hFF, 23'd0};
    else if (post_unf) post_res = {sign_q, 31'd0};
  end

`ifdef FPU_DIV_FLAGS_EN
  logic [4:0] flags_q;
  logic [4:0] post_flg;

  always_comb begin
    post_flg = '0;
    if (post_ovf) begin
      post_flg[FLAG_OF] = 1'b1;
      post_flg[FLAG_NX] = 1'b1;
    end else if (post_unf) begin
      post_flg[FLAG_UF] = 1'b1;
      post_flg[FLAG_NX] = 1'b1;
    end else begin
      post_flg[FLAG_NX] = (q[25] ? (|q[1:0]) : q[0]) | (|rem);
    end
  end

  assign o_flags = flags_q;
`else
  logic unused_bits;
  assign unused_bits = ^{spec_flg, q[0]};
  assign o_flags     = 5'b0;
`endif

  assign o_ready = (state == S_IDLE);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= S_IDLE;
      o_valid  <= 1'b0;
      o_result <= '0;
`ifdef FPU_DIV_FLAGS_EN
      flags_q  <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: if (i_valid) begin
          sign_q <= sa ^ sb;
          ea     <= (xa == '0) ? 10'sd1 : {2'b00, xa};
          eb     <= (xb == '0) ? 10'sd1 : {2'b00, xb};
          rem    <= {1'b0, xa != '0, fa};
          mb     <= {xb != '0, fb};
          q      <= '0;
          cnt    <= DIV_LAST;
          if (spec_hit) begin
            o_result <= spec_res;
`ifdef FPU_DIV_FLAGS_EN
            flags_q  <= spec_flg;
`endif
            o_valid  <= 1'b1;
            state    <= S_DONE;
          end else if (xa != '0 && xb != '0) begin
            state <= S_DIVIDE;
          end else begin
            state <= S_PRENORM;
          end
        end
        S_PRENORM: begin
          rem <= rem_sh;
          mb  <= mb_sh;
          ea  <= ea_sh;
          eb  <= eb_sh;
          if (rem_sh[23] && mb_sh[23]) state <= S_DIVIDE;
        end
        S_DIVIDE: begin
          rem <= rem_chain[RADIX_BITS];
          q   <= {q[25-RADIX_BITS:0], q_bits};
          cnt <= cnt - 5'd1;
          if (cnt == 5'd0) state <= S_POST;
        end
        S_POST: begin
          o_result <= post_res;
`ifdef FPU_DIV_FLAGS_EN
          flags_q  <= post_flg;
`endif
          o_valid  <= 1'b1;
          state    <= S_DONE;
        end
        S_DONE: if (i_ack) begin
          o_valid <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
